debug_unit: RTL

- Host-side controller that sits directly downstream of the pipeline top and consumes its debug outputs: instruccion, pc, if_id, id_ex, ex_m, m_wb and registros.
- Drives the pipeline's enable input, giving the host three modes: continuous run, single step and state dump.
- After a run or step, or on request, it serializes a fixed frame of pipeline state as bytes over a valid/ready interface to the UART transmitter.
- Takes command bytes from the UART receiver.

---
 rtl/debug_pkg.sv | 63 ++++++
 rtl/debug_frame_mux.sv | 48 ++++
 rtl/debug_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared constants, command codes, FSM state type and frame layout for the
// host-side pipeline debug controller (debug_unit) and its frame byte mux.
// Frame layout (byte offsets, every field sent MSB byte first):
//   0 header | 1 cycle counter | 5 pc | 6 if_id | 11 id_ex | 29 ex_m |
//   39 m_wb  | 49 registros (only when DEBUG_REGS_DUMP_EN is defined)
// -----------------------------------------------------------------------------
package debug_pkg;

    // Field widths
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CYC_W   = 32;
    localparam int unsigned PC_W    = 8;
    localparam int unsigned IFID_W  = 40;
    localparam int unsigned IDEX_W  = 144;
    localparam int unsigned EXM_W   = 80;
    localparam int unsigned MWB_W   = 80;
    localparam int unsigned REGS_W  = 1024;

    // Frame byte index width (covers the 177-byte extended frame)
    localparam int unsigned IDX_W   = 8;

    // Behavioural parameters
    localparam logic [INSTR_W-1:0] HALT_WORD    = 32'hFFFF_FFFF;
    localparam int unsigned        DRAIN_CYCLES = 4;
    localparam int unsigned        DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [BYTE_W-1:0]  FRAME_HDR    = 8'hA5;

    // Host command bytes
    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h63;  // 'c'
    localparam logic [BYTE_W-1:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [BYTE_W-1:0] CMD_DUMP = 8'h64;  // 'd'

    // Byte offsets of each field inside the dump frame
    localparam int unsigned OFF_CYC  = 1;
    localparam int unsigned OFF_PC   = OFF_CYC  + CYC_W  / BYTE_W;
    localparam int unsigned OFF_IFID = OFF_PC   + PC_W   / BYTE_W;
    localparam int unsigned OFF_IDEX = OFF_IFID + IFID_W / BYTE_W;
    localparam int unsigned OFF_EXM  = OFF_IDEX + IDEX_W / BYTE_W;
    localparam int unsigned OFF_MWB  = OFF_EXM  + EXM_W  / BYTE_W;
    localparam int unsigned OFF_REGS = OFF_MWB  + MWB_W  / BYTE_W;

    localparam int unsigned FRAME_LEN_BASE = 49;
    localparam int unsigned FRAME_LEN_REGS = 177;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4
    } state_e;

    // Byte k (0 = most significant) of a field nbytes long, right-aligned in field.
    function automatic logic [BYTE_W-1:0] msb_byte(input logic [REGS_W-1:0] field,
                                                   input int unsigned       nbytes,
                                                   input int unsigned       k);
        return BYTE_W'(field >> (BYTE_W * (nbytes - 1 - k)));
    endfunction

endpackage

// File: rtl/debug_frame_mux.sv
// -----------------------------------------------------------------------------
// debug_frame_mux
// Combinational selection of the dump-frame byte at a given frame index.
// Ports:
//   idx_i        frame byte index
//   cyc_i        enabled-cycle counter
//   pc_i, if_id_i, id_ex_i, ex_m_i, m_wb_i, registros_i  live pipeline images
//   byte_o       selected frame byte
// Build option: DEBUG_REGS_DUMP_EN appends registros after m_wb; otherwise
// registros_i is unused.
// -----------------------------------------------------------------------------
module debug_frame_mux
    import debug_pkg::*;
(
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [CYC_W-1:0]  cyc_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [IFID_W-1:0] if_id_i,
    input  logic [IDEX_W-1:0] id_ex_i,
    input  logic [EXM_W-1:0]  ex_m_i,
    input  logic [MWB_W-1:0]  m_wb_i,
    input  logic [REGS_W-1:0] registros_i,
    output logic [BYTE_W-1:0] byte_o
);

    logic [31:0] idx;
    assign idx = 32'(idx_i);

`ifndef DEBUG_REGS_DUMP_EN
    logic unused_regs;
    assign unused_regs = ^registros_i;
`endif

    // Fields are checked in ascending offset order; the last matching one wins.
    always_comb begin
        byte_o = FRAME_HDR;
        if (idx >= OFF_CYC)  byte_o = msb_byte(REGS_W'(cyc_i),   CYC_W  / BYTE_W, idx - OFF_CYC);
        if (idx >= OFF_PC)   byte_o = pc_i;
        if (idx >= OFF_IFID) byte_o = msb_byte(REGS_W'(if_id_i), IFID_W / BYTE_W, idx - OFF_IFID);
        if (idx >= OFF_IDEX) byte_o = msb_byte(REGS_W'(id_ex_i), IDEX_W / BYTE_W, idx - OFF_IDEX);
        if (idx >= OFF_EXM)  byte_o = msb_byte(REGS_W'(ex_m_i),  EXM_W  / BYTE_W, idx - OFF_EXM);
        if (idx >= OFF_MWB)  byte_o = msb_byte(REGS_W'(m_wb_i),  MWB_W  / BYTE_W, idx - OFF_MWB);
`ifdef DEBUG_REGS_DUMP_EN
        if (idx >= OFF_REGS) byte_o = msb_byte(registros_i,      REGS_W / BYTE_W, idx - OFF_REGS);
`endif
    end

endmodule

// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
// Host-side pipeline debug controller: takes command bytes from UART RX,
// drives the pipeline enable (continuous run / single step) and serializes a
// fixed frame of pipeline state to UART TX over a valid/ready handshake.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   rx_data, rx_valid      command byte from UART RX (one-cycle pulse)
//   tx_data, tx_valid      frame byte to UART TX, held until tx_ready
//   tx_ready               UART TX accepts the byte
//   pipe_enable            pipeline enable
//   instruccion, pc, if_id, id_ex, ex_m, m_wb, registros   pipeline debug images
//   busy                   controller not idle
//   halted                 HALT_WORD has been retired
// Build option: DEBUG_REGS_DUMP_EN extends the frame with registros (177 bytes).
// -----------------------------------------------------------------------------
module debug_unit
    import debug_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                pipe_enable,
    input  logic [INSTR_W-1:0]  instruccion,
    input  logic [PC_W-1:0]     pc,
    input  logic [IFID_W-1:0]   if_id,
    input  logic [IDEX_W-1:0]   id_ex,
    input  logic [EXM_W-1:0]    ex_m,
    input  logic [MWB_W-1:0]    m_wb,
    input  logic [REGS_W-1:0]   registros,
    output logic                busy,
    output logic                halted
);

`ifdef DEBUG_REGS_DUMP_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_REGS;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e              state_q,       state_d;
    logic [DRAIN_W-1:0]  drain_q,       drain_d;
    logic [IDX_W-1:0]    idx_q,         idx_d;
    logic [CYC_W-1:0]    cyc_q,         cyc_d;
    logic [BYTE_W-1:0]   tx_data_q,     tx_data_d;
    logic                tx_valid_q,    tx_valid_d;
    logic                pipe_enable_q, pipe_enable_d;
    logic                busy_q,        busy_d;
    logic                halted_q,      halted_d;
    logic                tx_load;
    logic [BYTE_W-1:0]   frame_byte;

    // Frame byte for the index that will be presented next cycle
    debug_frame_mux u_frame_mux (
        .idx_i       (idx_d),
        .cyc_i       (cyc_q),
        .pc_i        (pc),
        .if_id_i     (if_id),
        .id_ex_i     (id_ex),
        .ex_m_i      (ex_m),
        .m_wb_i      (m_wb),
        .registros_i (registros),
        .byte_o      (frame_byte)
    );

    // Next-state logic for the control FSM and frame index
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        idx_d      = idx_q;
        tx_valid_d = tx_valid_q;
        halted_d   = halted_q;
        tx_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_RUN:  if (!halted_q) state_d = ST_RUN;
                        CMD_STEP: if (!halted_q) state_d = ST_STEP;
                        CMD_DUMP: begin
                            state_d = ST_DUMP;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end

            // pipe_enable is high for every cycle spent in RUN
            ST_RUN: begin
                if (instruccion == HALT_WORD) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                end
            end

            ST_DRAIN: begin
                if (drain_q <= DRAIN_W'(1)) begin
                    state_d  = ST_DUMP;
                    idx_d    = '0;
                    halted_d = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end

            ST_STEP: begin
                state_d = ST_DUMP;
                idx_d   = '0;
            end

            // First DUMP cycle only loads byte 0; afterwards each accepted
            // byte is immediately replaced by the next one.
            ST_DUMP: begin
                if (!tx_valid_q) begin
                    tx_load    = 1'b1;
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_load = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Registered output values derived from the next state
    always_comb begin
        tx_data_d     = tx_load ? frame_byte : tx_data_q;
        pipe_enable_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
        busy_d        = (state_d != ST_IDLE);
        cyc_d         = pipe_enable_q ? cyc_q + CYC_W'(1) : cyc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            drain_q       <= '0;
            idx_q         <= '0;
            cyc_q         <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            pipe_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            idx_q         <= idx_d;
            cyc_q         <= cyc_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            pipe_enable_q <= pipe_enable_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign pipe_enable = pipe_enable_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule
